// File: rtl/fast_inv_sqrt_pkg.sv
// Shared types and constants for the fast inverse square root datapath
// and its sum-of-squares front end.
package fast_inv_sqrt_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int SQ_WIDTH   = 2 * WORD_WIDTH;

    localparam logic [WORD_WIDTH-1:0] SAT_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        OUT
    } sum_sq_state_t;

endpackage

// File: rtl/sum_sq_accum_fix_square.sv
// Stage 1 of sum_sq_accum: registered signed WIDTH x WIDTH squarer with
// valid and last sideband carried alongside the product.
module fix_square
    import fast_inv_sqrt_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data,
    input  logic                 valid,
    input  logic                 last,
    output logic [2*WIDTH-1:0]   sq,
    output logic                 sq_valid,
    output logic                 sq_last
);

    logic [2*WIDTH-1:0] ext;
    logic [2*WIDTH-1:0] prod;

    // Sign-extend first so the low 2*WIDTH bits of the product are the exact
    // square; a square is never negative, so the result is read as unsigned.
    always_comb begin
        ext  = {{WIDTH{data[WIDTH-1]}}, data};
        prod = ext * ext;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq       <= '0;
            sq_valid <= 1'b0;
            sq_last  <= 1'b0;
        end else begin
            sq_valid <= valid;
            sq_last  <= valid && last;
            if (valid) begin
                sq <= prod;
            end
        end
    end

endmodule

// File: rtl/sum_sq_accum.sv
// Streaming sum-of-squares |v|^2 ahead of the inverse square root unit.
// Build option: SUM_SQ_ROUND_EN selects round-half-up instead of truncation.
module sum_sq_accum
    import fast_inv_sqrt_pkg::*;
#(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int MAX_LEN     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]   data_in,
    input  logic                               last_in,
    input  logic                               valid_in,
    output logic                               ready_in,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]   data_out,
    output logic                               sat_out,
    output logic                               len_err_out,
    output logic                               valid_out,
    input  logic                               ready_out
);

    localparam int W     = INT_WIDTH + FRACT_WIDTH;
    localparam int SQ_W  = 2 * W;
    localparam int ACC_W = SQ_W + $clog2(MAX_LEN) + 1;
    localparam int CNT_W = $clog2(MAX_LEN) + 1;

`ifdef SUM_SQ_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (FRACT_WIDTH - 1);
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    sum_sq_state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             len_err_r;
    logic [SQ_W-1:0]  sq;
    logic             sq_valid, sq_last;

    logic             accept, at_max, end_beat, handshake, ready_next;
    logic [ACC_W-1:0] rounded, scaled;
    logic             res_sat;
    logic [W-1:0]     res_data;

    assign accept    = valid_in && ready_in;
    assign at_max    = (cnt == CNT_W'(MAX_LEN - 1));
    assign end_beat  = accept && (last_in || at_max);
    assign handshake = (state == OUT) && ready_out;

    fix_square #(.WIDTH(W)) u_square (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data_in),
        .valid    (accept),
        .last     (last_in || at_max),
        .sq       (sq),
        .sq_valid (sq_valid),
        .sq_last  (sq_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACC;
        else        state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ACC:     if (sq_valid && sq_last) next_state = DRAIN;
            DRAIN:   next_state = OUT;
            OUT:     if (ready_out) next_state = ACC;
            default: next_state = ACC;
        endcase
    end

    // ready_in is registered: it drops on the ending beat and rises on the
    // result handshake, so ready_out never reaches ready_in combinationally.
    always_comb begin
        ready_next = 1'b0;
        rounded    = acc + RND;
        scaled     = rounded >> FRACT_WIDTH;
        res_sat    = scaled > ACC_W'(SAT_VALUE);
        res_data   = res_sat ? W'(SAT_VALUE) : scaled[W-1:0];
        if (state == ACC)
            ready_next = !end_beat && !(sq_valid && sq_last);
        else if (handshake)
            ready_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_in    <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            len_err_r   <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            sat_out     <= 1'b0;
            len_err_out <= 1'b0;
        end else begin
            ready_in <= ready_next;
            if (handshake) begin
                cnt         <= '0;
                acc         <= '0;
                len_err_r   <= 1'b0;
                valid_out   <= 1'b0;
                sat_out     <= 1'b0;
                len_err_out <= 1'b0;
            end else begin
                if (accept) begin
                    cnt <= cnt + CNT_W'(1);
                    if (at_max && !last_in) len_err_r <= 1'b1;
                end
                if (sq_valid) acc <= acc + ACC_W'(sq);
                if (state == DRAIN) begin
                    valid_out   <= 1'b1;
                    data_out    <= res_data;
                    sat_out     <= res_sat;
                    len_err_out <= len_err_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_sq_accum.sv
// Scoreboard bench for sum_sq_accum: directed cases plus random vectors
// against a plain-arithmetic reference model of |v|^2.
module tb_sum_sq_accum;

    localparam int MAX_LEN = 4;
    localparam int FR      = 4;
`ifdef SUM_SQ_ROUND_EN
    localparam longint RND = 8;
`else
    localparam longint RND = 0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic        len_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        last_in, valid_in, ready_in;
    logic [15:0] data_out;
    logic        sat_out, len_err_out, valid_out, ready_out;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_sum    = 0;
    int     m_cnt    = 0;
    bit     use_model = 1'b1;

    always #5 clk = ~clk;

    sum_sq_accum #(.INT_WIDTH(12), .FRACT_WIDTH(FR), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .last_in     (last_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .sat_out     (sat_out),
        .len_err_out (len_err_out),
        .valid_out   (valid_out),
        .ready_out   (ready_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expected_of(input longint sum, input bit len_err);
        exp_t   e;
        longint r;
        r         = (sum + RND) / (64'sd1 << FR);
        e.sat     = (r > 65535);
        e.data    = e.sat ? 16'hFFFF : 16'(r);
        e.len_err = len_err;
        return e;
    endfunction

    // Reference: a vector closes on last or on its MAX_LENth beat.
    task automatic model_beat(input logic [15:0] d, input logic l);
        int sd;
        sd = int'($signed(d));
        m_sum += longint'(sd) * longint'(sd);
        m_cnt++;
        if (l || m_cnt == MAX_LEN) begin
            if (use_model) sb.push_back(expected_of(m_sum, !l));
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic s, input logic le);
        exp_t e;
        e.data = d; e.sat = s; e.len_err = le;
        sb.push_back(e);
    endtask

    // Called and returns at a falling edge; waited = cycles stalled on ready_in.
    task automatic send_beat(input logic [15:0] d, input logic l, output int waited);
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        waited   = 0;
        while (!ready_in && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("beat_accepted", 32'(ready_in), 32'd1);
        @(negedge clk);
        model_beat(d, l);
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
    endtask

    task automatic send_vec(input logic [15:0] v[$], input bit with_last);
        int w;
        foreach (v[i]) send_beat(v[i], with_last && (i == v.size() - 1), w);
        idle();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("valid_out_arrives", 32'(valid_out), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || valid_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_in"},  32'(ready_in),    32'd0);
        check({tag, "_valid_out"}, 32'(valid_out),   32'd0);
        check({tag, "_data_out"},  32'(data_out),    32'd0);
        check({tag, "_sat_out"},   32'(sat_out),     32'd0);
        check({tag, "_len_err"},   32'(len_err_out), 32'd0);
    endtask

    // Monitor: compares each result at the cycle its handshake will happen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(valid_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result_data",    32'(data_out),    32'(e.data));
                    check("result_sat",     32'(sat_out),     32'(e.sat));
                    check("result_len_err", 32'(len_err_out), 32'(e.len_err));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v[$];
        logic [15:0] cap_d;
        logic        cap_s, cap_l;
        int          w, len;

        rst_n = 1'b0; ready_out = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_in), 32'd1);

        // 3.0^2 + 4.0^2 = 25.0, two-cycle latency from the last beat
        use_model = 1'b0;
        push_exp(16'h0190, 1'b0, 1'b0);
        v = '{16'h0030, 16'h0040};
        send_vec(v, 1'b1);
        check("ready_low_after_end", 32'(ready_in),  32'd0);
        check("latency_t0",          32'(valid_out), 32'd0);
        @(negedge clk);
        check("latency_t1",          32'(valid_out), 32'd0);
        @(negedge clk);
        check("latency_t2",          32'(valid_out), 32'd1);
        wait_idle();

        push_exp(16'h0090, 1'b0, 1'b0); v = '{16'hFFD0}; send_vec(v, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0); v = '{16'h0000}; send_vec(v, 1'b1);
        push_exp((RND != 0) ? 16'h0001 : 16'h0000, 1'b0, 1'b0);
        v = '{16'h0003}; send_vec(v, 1'b1);
        push_exp(16'hF810, 1'b0, 1'b0); v = '{16'h03F0}; send_vec(v, 1'b1);
        push_exp(16'hFFFF, 1'b1, 1'b0); v = '{16'h0400}; send_vec(v, 1'b1);
        wait_idle();

        // Forced end at MAX_LEN; the fifth beat opens the next vector.
        push_exp(16'h0040, 1'b0, 1'b1);
        push_exp(16'h0050, 1'b0, 1'b0);
        v = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0020};
        send_vec(v, 1'b1);
        wait_idle();
        use_model = 1'b1;

        // Back-pressure: result held for 10 cycles.
        ready_out = 1'b0;
        v = '{16'h0123, 16'hFE77, 16'h0042};
        send_vec(v, 1'b1);
        wait_valid();
        cap_d = data_out; cap_s = sat_out; cap_l = len_err_out;
        repeat (10) begin
            @(negedge clk);
            check("hold_data",     32'(data_out),    32'(cap_d));
            check("hold_sat",      32'(sat_out),     32'(cap_s));
            check("hold_len_err",  32'(len_err_out), 32'(cap_l));
            check("hold_valid",    32'(valid_out),   32'd1);
            check("hold_ready_in", 32'(ready_in),    32'd0);
        end
        ready_out = 1'b1;
        @(negedge clk);
        check("ready_after_handshake", 32'(ready_in),  32'd1);
        check("valid_after_handshake", 32'(valid_out), 32'd0);

        // Back-to-back random vectors: no bubbles inside a vector, and the
        // next vector starts right after the previous result's handshake.
        for (int k = 0; k < 20; k++) begin
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) begin
                logic [15:0] d;
                if ($urandom_range(0, 3) == 0) d = 16'($urandom);
                else                           d = 16'($urandom_range(0, 1023)) - 16'd512;
                send_beat(d, i == len - 1, w);
                if (i > 0)       check("no_bubble", 32'(w), 32'd0);
                else if (k == 0) check("first_after_hold", 32'(w), 32'd0);
                else             check("vector_gap", 32'(w), 32'd3);
            end
        end
        idle();
        wait_idle();

        // Random lengths, some beyond MAX_LEN, with and without last.
        for (int k = 0; k < 20; k++) begin
            v.delete();
            len = $urandom_range(1, MAX_LEN + 3);
            for (int i = 0; i < len; i++) v.push_back(16'($urandom_range(0, 4095)) - 16'd2048);
            send_vec(v, 1'b1);
        end
        wait_idle();

        // Reset mid-vector discards the partial sum.
        v = '{16'h0100, 16'h0200};
        send_vec(v, 1'b0);
        rst_n = 1'b0;
        m_sum = 0; m_cnt = 0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a result is held discards it.
        ready_out = 1'b0;
        v = '{16'h0050};
        send_vec(v, 1'b1);
        wait_valid();
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_out");
        rst_n = 1'b1; ready_out = 1'b1;
        @(negedge clk);
        check("ready_after_rst_out", 32'(ready_in), 32'd1);

        use_model = 1'b0;
        push_exp(16'h0010, 1'b0, 1'b0);
        v = '{16'h0010};
        send_vec(v, 1'b1);
        wait_idle();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_sq_accum.md
# sum_sq_accum

Streaming sum-of-squares stage directly upstream of the fast inverse square root unit. Accepts a vector of signed fixed-point components one per beat, squares and accumulates them, and emits the unsigned squared magnitude |v|² in the same Q(INT_WIDTH).(FRACT_WIDTH) format on a valid/ready interface. The inverse square root unit consumes this value, so the pair yields 1/|v| for vector normalisation.

## Interface
- `INT_WIDTH`, 12: integer bits of input and output words.
- `FRACT_WIDTH`, 4: fractional bits; INT_WIDTH+FRACT_WIDTH = 16.
- `MAX_LEN`, 4: maximum components per vector, ≥1.

Reset is synchronous and active-low. The block has a single clock.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `data_in`  in  16  signed two's-complement component.
- `last_in`  in  1  marks final component of vector.
- `valid_in`  in  1  upstream beat valid.
- `ready_in`  out  1  block accepts a beat.
- `data_out`  out  16  unsigned |v|², same Q format.
- `sat_out`  out  1  result saturated.
- `len_err_out`  out  1  vector truncated at MAX_LEN.
- `valid_out`  out  1  result valid.
- `ready_out`  in  1  downstream accepts result.

## Operation
- States: ACC (accepting), DRAIN (last square in flight), OUT (holding result).
- Beat accepted on `valid_in && ready_in` at a rising edge.
- Stage 1: square registered. `data_in`² is 32-bit unsigned in Q(2·INT).(2·FRACT) format.
- Stage 2: square added to the accumulator. The accumulator is 32+$clog2(MAX_LEN)+1 bits and cannot overflow.
- Beat counter counts accepted beats. The vector ends on `last_in`, or on the MAX_LENth beat. In the second case `len_err_out`=1 for that result.
- Beats offered after a forced end belong to the next vector.
- Result = (acc + rnd) >> FRACT_WIDTH. If it exceeds 16'hFFFF, `data_out`=16'hFFFF and `sat_out`=1.
- Zero vector gives `data_out`=0. This is a legal result; no flag is raised.
- Accumulator, counter and flags clear on entry to ACC.

## Timing
- Reset values: `ready_in`=0, `valid_out`=0, `data_out`=0, `sat_out`=0, `len_err_out`=0, state ACC.
- `ready_in`=1 from the first cycle after `rst_n` deasserts.
- In ACC, one beat is accepted per cycle with no bubbles.
- Ending beat accepted at edge t:
  - `ready_in` low from t onward.
  - State DRAIN at t+1.
  - At t+2: `valid_out`=1, `data_out`, `sat_out` and `len_err_out` registered.
  - Latency from last beat to result is 2 cycles.
- OUT: outputs stay stable while `valid_out && !ready_out`.
- On a result handshake at edge u: `valid_out`=0 at u, state ACC, `ready_in`=1 at u. The next vector can start at u+1.
- `ready_out` is ignored outside OUT. No combinational path from `ready_out` to `ready_in`.
- `rst_n` low in any state returns every register to its reset value at that edge. A partial vector or held result is discarded.

## Configuration
- `SUM_SQ_ROUND_EN` defined: rnd = 1<<(FRACT_WIDTH-1), round-half-up.
- `SUM_SQ_ROUND_EN` undefined: rnd = 0, truncation.
- Saturation applies after rounding in both builds.

## Structure
- Shared package `fast_inv_sqrt_pkg` holds:
  - the `sum_sq_state_t` enum (ACC, DRAIN, OUT);
  - WORD_WIDTH and SQ_WIDTH localparams;
  - the 16'hFFFF saturation constant.
- Sub-module `fix_square`: registered signed 16×16 → 32-bit unsigned squarer (stage 1), with valid and last sideband.

## Test plan
- (0x0030, 0x0040+last), ready_out=1 → `data_out`=0x0190 (25.0), flags 0, valid_out 2 cycles after last.
- (0xFFD0+last) (-3.0) → `data_out`=0x0090. (0x0000+last) → 0x0000, `valid_out`=1.
- (0x0003+last) → 0x0001 with `SUM_SQ_ROUND_EN`, 0x0000 without. (0x03F0+last) → 0xF810. (0x0400+last) → 0xFFFF, `sat_out`=1.
- MAX_LEN=4: five beats of 0x0010, no last → first result 0x0040 with `len_err_out`=1. Fifth beat starts the next vector.
- Hold `ready_out`=0 for 10 cycles in OUT:
  - `data_out` and flags stable, `ready_in`=0;
  - `ready_in`=1 the cycle after the handshake;
  - back-to-back vectors then run without extra bubbles.
- Drop `rst_n` mid-vector and in OUT → all outputs at reset values next edge. Fresh vector (0x0010+last) → 0x0010.
